// File: rtl/modarith_pkg.sv
// modarith_pkg: shared definitions for the modular add/sub datapath.
// Holds the lane op encoding, the sparse effective-modulus builder and
// lane slice helpers for the packed LANES*LOGQ operand/result buses.
package modarith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest modulus the helper function supports; callers cast in and out.
  localparam int QMAX = 128;

  // Effective modulus for sparse moduli: bits [reduc-1:1] are forced to zero
  // so the reduction adders see a mostly-constant operand; bit 0 is kept.
  function automatic logic [QMAX-1:0] sparse_q(input logic [QMAX-1:0] q,
                                               input int reduc);
    logic [QMAX-1:0] mask;
    mask = '1;
    for (int i = 1; i < QMAX; i++) begin
      if (i < reduc) mask[i] = 1'b0;
    end
    return q & mask;
  endfunction

  // Lowest bit index of lane 'lane' in a bus packed as lanes of width w.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/modaddsub_lane.sv
// modaddsub_lane: per-lane stage-1 candidate/select generation (pure comb).
// Latency: 0 cycles; no handshake, the parent pipeline owns all state.
// Ports: op (0 add / 1 sub), a, b, qe in; res (primary candidate),
//        alt (alternate candidate), sel (1 = pick alt) out.
module modaddsub_lane
  import modarith_pkg::*;
#(
  parameter int LOGQ = 64
) (
  input  logic            op,
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  input  logic [LOGQ-1:0] qe,
  output logic [LOGQ-1:0] res,
  output logic [LOGQ-1:0] alt,
  output logic            sel
);

  logic [LOGQ:0]   r;   // A - B with borrow in the top bit
  logic [LOGQ-1:0] rq;  // low bits of R + qe
  logic [LOGQ:0]   s;   // A + B with carry
  logic [LOGQ-1:0] t;   // low bits of S - qe

  always_comb begin
    r   = {1'b0, a} - {1'b0, b};
    rq  = r[LOGQ-1:0] + qe;
    s   = {1'b0, a} + {1'b0, b};
    t   = s[LOGQ-1:0] - qe;
    res = '0;
    alt = '0;
    sel = 1'b0;
    if (op == OP_SUB) begin
      // Borrow means A < B: the wrapped difference needs qe added back.
      res = r[LOGQ-1:0];
      alt = rq;
      sel = r[LOGQ];
    end else begin
      // S - qe is negative exactly when S < qe; then keep S unreduced.
      res = t;
      alt = s[LOGQ-1:0];
      sel = (s < {1'b0, qe});
    end
  end

endmodule

// File: rtl/modaddsub_pipe.sv
// modaddsub_pipe: multi-lane (A +/- B) mod q with per-lane op select.
// Latency: 2 cycles, 1 transaction/cycle; a single global advance moves both stages.
// Backpressure: out_valid && !out_ready freezes both stages and drops in_ready.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready, in_op[LANES],
//        in_a/in_b[LANES*LOGQ], in_q[LOGQ]; out_valid/out_ready, out_c[LANES*LOGQ].
// Build option: MODADDSUB_GENERIC_Q_EN uses in_q verbatim as the modulus;
//               when undefined the sparse modulus (Reduc_param) is used.
module modaddsub_pipe
  import modarith_pkg::*;
#(
  parameter int LOGQ        = 64,
  parameter int Reduc_param = 17,
  parameter int LANES       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_op,
  input  logic [LANES*LOGQ-1:0] in_a,
  input  logic [LANES*LOGQ-1:0] in_b,
  input  logic [LOGQ-1:0]       in_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LOGQ-1:0] out_c
);

  logic            adv;
  logic [LOGQ-1:0] qe;

  logic [LANES-1:0][LOGQ-1:0] l_res, l_alt;
  logic [LANES-1:0]           l_sel;

  logic                       s1_vld;
  logic [LANES-1:0][LOGQ-1:0] s1_res, s1_alt;
  logic [LANES-1:0]           s1_sel;
  logic [LANES-1:0][LOGQ-1:0] c_nxt;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_n;

`ifdef MODADDSUB_GENERIC_Q_EN
  assign qe = in_q;
`else
  assign qe = LOGQ'(sparse_q(QMAX'(in_q), Reduc_param));
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    modaddsub_lane #(.LOGQ(LOGQ)) u_lane (
      .op  (in_op[i]),
      .a   (in_a[lane_lo(i, LOGQ) +: LOGQ]),
      .b   (in_b[lane_lo(i, LOGQ) +: LOGQ]),
      .qe  (qe),
      .res (l_res[i]),
      .alt (l_alt[i]),
      .sel (l_sel[i])
    );
  end

  // Stage 2 mux: pick the registered candidate per lane.
  always_comb begin
    c_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      c_nxt[i] = s1_sel[i] ? s1_alt[i] : s1_res[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_res    <= '0;
      s1_alt    <= '0;
      s1_sel    <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
    end else if (adv) begin
      // in_ready == adv here, so in_valid alone marks an accepted input.
      s1_vld    <= in_valid;
      s1_res    <= l_res;
      s1_alt    <= l_alt;
      s1_sel    <= l_sel;
      out_valid <= s1_vld;
      out_c     <= c_nxt;
    end
  end

endmodule

// File: tb/tb_modaddsub_pipe.sv
module tb_modaddsub_pipe;
  localparam int LOGQ  = 16;
  localparam int RP    = 8;
  localparam int LANES = 4;

`ifdef MODADDSUB_GENERIC_Q_EN
  localparam logic [15:0] MACRO_EXP = 16'h0000;
`else
  localparam logic [15:0] MACRO_EXP = 16'h0006;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0]      in_op;
  logic [LANES*LOGQ-1:0] in_a, in_b;
  logic [LOGQ-1:0]       in_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*LOGQ-1:0] out_c;

  always #5 clk = ~clk;

  modaddsub_pipe #(.LOGQ(LOGQ), .Reduc_param(RP), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: plain modular arithmetic on integers.
  function automatic int unsigned eff_q(input logic [15:0] q);
    int unsigned qq, low;
    qq  = q;
    low = (1 << RP) - 1;
`ifdef MODADDSUB_GENERIC_Q_EN
    return qq;
`else
    return (qq & ~low) | (qq & 1);
`endif
  endfunction

  function automatic logic [15:0] ref_lane(input bit sub, input int unsigned a, b, qe);
    int d;
    int unsigned s;
    if (sub) begin
      d = int'(a) - int'(b);
      if (d < 0) d = d + int'(qe);
      return 16'(d);
    end else begin
      s = a + b;
      if (s >= qe) s = s - qe;
      return 16'(s);
    end
  endfunction

  function automatic logic [63:0] ref_txn(input logic [3:0] op, input logic [63:0] a, b,
                                          input logic [15:0] q);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*16 +: 16] = ref_lane(op[i], a[i*16 +: 16], b[i*16 +: 16], eff_q(q));
    return r;
  endfunction

  logic [63:0] exp_q[$];
  int          acc_q[$];
  int          cyc = 0;
  int          acc_cnt = 0;
  bit          prev_stall = 0;
  bit          prev_rst = 0;
  bit          lat_chk = 0;
  logic [63:0] prev_c;

  // One clock cycle: check outputs at negedge, drive inputs, log handshakes.
  task automatic step(input logic iv, input logic [3:0] op, input logic [63:0] a, b,
                      input logic [15:0] q, input logic ordy, input logic rstn,
                      input bit use_exp, input logic [63:0] exp_v);
    logic [63:0] e;
    int          ac;
    @(negedge clk);
    if (prev_stall) begin
      check("stall_vld", out_valid, 1);
      check("stall_dat", out_c, prev_c);
    end
    if (prev_rst && rstn) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_out_c", out_c, 0);
    end
    rst_n = rstn; in_valid = iv; in_op = op; in_a = a; in_b = b; in_q = q;
    out_ready = ordy;
    #1;
    if (!rstn) check("rst_in_ready", in_ready, 0);
    else if (out_valid && !out_ready) check("full_in_ready", in_ready, 0);
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
      else begin
        e  = exp_q.pop_front();
        ac = acc_q.pop_front();
        check("data", out_c, e);
        if (lat_chk) check("latency", 64'(cyc - ac), 2);
      end
    end
    if (rstn && iv && in_ready) begin
      exp_q.push_back(use_exp ? exp_v : ref_txn(op, a, b, q));
      acc_q.push_back(cyc);
      acc_cnt++;
    end
    if (!rstn) begin
      exp_q.delete();
      acc_q.delete();
    end
    prev_stall = rstn && out_valid && !out_ready;
    prev_rst   = !rstn;
    prev_c     = out_c;
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(0, 4'h0, 64'h0, 64'h0, 16'h3301, ordy, 1, 0, 64'h0);
  endtask

  function automatic logic [15:0] rand_q();
    logic [7:0] hi;
    hi = 8'($urandom_range(8'h80, 8'hFF));
    return {hi, 7'b0, 1'b1};
  endfunction

  task automatic rand_ops(input logic [15:0] q, output logic [63:0] a, b);
    int unsigned qe;
    qe = eff_q(q);
    for (int i = 0; i < LANES; i++) begin
      a[i*16 +: 16] = 16'($urandom_range(0, qe - 1));
      b[i*16 +: 16] = 16'($urandom_range(0, qe - 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] a, b;
    logic [15:0] q;
    logic [3:0]  op;
    int          n;
    rst_n = 0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_q = 0; out_ready = 0;

    // Reset, then directed vectors with latency checking.
    step(0, 4'h0, 64'h0, 64'h0, 16'h3301, 1, 0, 0, 64'h0);
    step(0, 4'h0, 64'h0, 64'h0, 16'h3301, 1, 0, 0, 64'h0);
    lat_chk = 1;
    // lanes: sub(5,7), sub(1234,1234), add(3300,2), add(1000,0100)
    step(1, 4'b0011, {16'h1000, 16'h3300, 16'h1234, 16'h0005},
         {16'h0100, 16'h0002, 16'h1234, 16'h0007}, 16'h3301, 1, 1,
         1, {16'h1100, 16'h0001, 16'h0000, 16'h32FF});
    // add exact -> 0 in lane 0; sub mirrors in other lanes
    step(1, 4'b1110, {16'h0000, 16'h0007, 16'h32FF, 16'h3300},
         {16'h0001, 16'h0005, 16'h0001, 16'h0001}, 16'h3301, 1, 1,
         1, {16'h3300, 16'h0002, 16'h32FE, 16'h0000});
    // mixed lanes, op = 0101, random in-range operands
    for (int k = 0; k < 3; k++) begin
      rand_ops(16'h3301, a, b);
      step(1, 4'b0101, a, b, 16'h3301, 1, 1, 0, 64'h0);
    end
    // modulus-configuration case
    step(1, 4'b0000, 64'h0000_0000_0000_3306, 64'h0000_0000_0000_0001, 16'h3307, 1, 1,
         1, {48'h0, MACRO_EXP});
    for (int k = 0; k < 3; k++) idle(1);

    // Random stream under pseudo-random backpressure.
    lat_chk = 0;
    n = acc_cnt;
    for (int k = 0; k < 600 && acc_cnt < n + 20; k++) begin
      q  = rand_q();
      op = 4'($urandom);
      rand_ops(q, a, b);
      step(1'($urandom_range(0, 3) != 0), op, a, b, q, 1'($urandom_range(0, 2) != 0), 1, 0, 64'h0);
    end
    check("bp_accepted", 64'(acc_cnt - n), 20);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
    check("bp_drain", 64'(exp_q.size()), 0);
    idle(1);

    // Reset with two transactions in flight; neither may appear afterwards.
    lat_chk = 1;
    for (int k = 0; k < 2; k++) begin
      rand_ops(16'h3301, a, b);
      step(1, 4'($urandom), a, b, 16'h3301, 1, 1, 0, 64'h0);
    end
    step(0, 4'h0, 64'h0, 64'h0, 16'h3301, 0, 0, 0, 64'h0);
    rand_ops(16'h3301, a, b);
    step(1, 4'b1010, a, b, 16'h3301, 1, 1, 0, 64'h0);
    for (int k = 0; k < 4; k++) idle(1);
    check("final_drain", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/modaddsub_pipe.md
# modaddsub_pipe

Pipelined, multi-lane modular adder/subtractor for the NTT butterfly datapath. It computes (A + B) mod q or (A − B) mod q independently per lane, with a per-lane operation select. It uses a valid/ready handshake with full backpressure and a fixed two-cycle latency. It sits between the operand fetch buffers and the butterfly write-back, replacing single-lane combinational modular subtraction where throughput and timing closure matter.

## Interface
Parameters:
- LOGQ, 64, coefficient/modulus width in bits.
- Reduc_param, 17, sparse-modulus split: q bits [Reduc_param-1:1] are treated as zero; q[0] is used; valid range 2..LOGQ-1.
- LANES, 4, independent coefficient lanes per transaction.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept input this cycle.
- in_op  in  LANES  per-lane op: 0 = add, 1 = sub.
- in_a  in  LANES*LOGQ  lane i operand A at [i*LOGQ +: LOGQ].
- in_b  in  LANES*LOGQ  lane i operand B, same packing.
- in_q  in  LOGQ  modulus, sampled with the transaction, shared by all lanes.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_c  out  LANES*LOGQ  results, same packing.

## Operation
- Preconditions: A, B < q and q odd. Out-of-range operands give unspecified values but must not corrupt other lanes or the handshake.
- Effective modulus qe = {q[LOGQ-1:Reduc_param], (Reduc_param-1) zeros, q[0]}.
- Sub, stage 1: R = A − B in LOGQ+1 bits; Rq = R + qe.
- Sub, stage 2: C = R[LOGQ] ? Rq[LOGQ-1:0] : R[LOGQ-1:0].
- Add, stage 1: S = A + B in LOGQ+1 bits; T = S − qe in LOGQ+2 bits.
- Add, stage 2: C = T negative ? S[LOGQ-1:0] : T[LOGQ-1:0].
- Stage 1 registers both candidates and the select bit per lane. Stage 2 registers the selected result.
- Lanes are fully independent. Mixed add/sub in one transaction is legal.

## Timing
- Two pipeline stages with a global advance: adv = !out_valid || out_ready.
- in_ready = adv && rst_n.
- An input accepted in cycle t (in_valid && in_ready) appears on out_c with out_valid in cycle t+2 if out_ready stays high. Throughput is 1 transaction per cycle.
- Stall: with out_valid=1 and out_ready=0, both stages hold and in_ready=0. Data is held stable until accepted, with no loss or duplication.
- Bubbles: stage valid bits propagate. A bubble in stage 1 may advance while the output is unaccepted only if out_valid=0, as covered by the adv rule.
- Reset: with rst_n=0 at a clock edge, both stage valids go to 0 and out_c and stage data go to 0. Any in-flight transactions are discarded. in_ready=0 while rst_n=0. out_valid=0 in the first cycle after release.
- Simultaneous accept in and accept out while full is legal and keeps full throughput.

## Configuration
- MODADDSUB_GENERIC_Q_EN:
  - Defined: qe = in_q exactly (any odd q < 2^LOGQ); Reduc_param is ignored.
  - Undefined: sparse qe as in Operation, which saves adder area.
- Latency and handshake are identical in both builds.

## Structure
- Package modarith_pkg holds:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - Function sparse_q(q) building qe.
  - Lane slice helpers for the packed buses.
- Sub-module modaddsub_lane: the per-lane stage-1 combinational candidate/select generation, instantiated LANES times. Registers and handshake stay in the top module.

## Test plan
Setup: LOGQ=16, Reduc_param=8, LANES=4, q=0x3301 unless noted.
- Sub borrow: A=0x0005, B=0x0007, op=sub → C=0x32FF at t+2. Sub equal: A=B=0x1234 → 0x0000.
- Add wrap: A=0x3300, B=0x0002 → 0x0001. Add no wrap: A=0x1000, B=0x0100 → 0x1100. Add exact: A=0x3300, B=0x0001 → 0x0000.
- Mixed lanes: op=4'b0101 with per-lane distinct operands → each lane matches a golden model; no cross-lane effect.
- Backpressure: stream 20 random transactions with out_ready toggled pseudo-randomly → in-order, no drops or duplicates, out_c stable while stalled, in_ready=0 when full and stalled.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 transactions in flight → out_valid=0 next cycle, neither transaction emitted, next accepted input returns correctly at t+2.
- Macro: q=0x3307, Add A=0x3306, B=0x0001:
  - With MODADDSUB_GENERIC_Q_EN: → 0x0000.
  - Without it (qe=0x3301): → 0x0006.
